// File: rtl/palette_mapper_pipe.sv
// Programmable colour-index to RGB mapper for the VGA path: writable palette with
// per-entry blink, blanking of invalid pixels and a fixed two-clock registered output.
module palette_mapper_pipe #(
    parameter int IDX_W        = 4,
    parameter int CH_W         = 8,
    parameter int BLINK_FRAMES = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_start,
    input  logic              pix_valid,
    input  logic [IDX_W-1:0]  color,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [3*CH_W-1:0] wr_rgb,
    input  logic              wr_blink,
    output logic [CH_W-1:0]   VGA_R,
    output logic [CH_W-1:0]   VGA_G,
    output logic [CH_W-1:0]   VGA_B,
    output logic              out_valid
);

    localparam int DEPTH = 2 ** IDX_W;
    localparam int CNT_W = $clog2(BLINK_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    // Power-on colour table at 8 bits per channel; anything past 15 is white.
    function automatic logic [23:0] default_rgb8(input int unsigned idx);
        logic [23:0] rgb;
        case (idx)
            32'd0:   rgb = {8'd127, 8'd127, 8'd127};
            32'd1:   rgb = {8'd255, 8'd0,   8'd0  };
            32'd2:   rgb = {8'd0,   8'd255, 8'd0  };
            32'd3:   rgb = {8'd0,   8'd0,   8'd255};
            32'd4:   rgb = {8'd255, 8'd255, 8'd0  };
            32'd5:   rgb = {8'd255, 8'd0,   8'd255};
            32'd6:   rgb = {8'd0,   8'd255, 8'd255};
            32'd7:   rgb = {8'd127, 8'd0,   8'd127};
            32'd8:   rgb = {8'd127, 8'd127, 8'd0  };
            32'd9:   rgb = {8'd0,   8'd127, 8'd127};
            32'd12:  rgb = {8'd96,  8'd96,  8'd96 };
            32'd13:  rgb = {8'd64,  8'd64,  8'd64 };
            32'd15:  rgb = {8'd0,   8'd0,   8'd0  };
            default: rgb = {8'd255, 8'd255, 8'd255};
        endcase
        return rgb;
    endfunction

    // Narrow channels keep the most significant bits of the 8-bit defaults.
    function automatic logic [3*CH_W-1:0] default_entry(input int unsigned idx);
        logic [23:0] rgb8;
        rgb8 = default_rgb8(idx);
        return {rgb8[23 -: CH_W], rgb8[15 -: CH_W], rgb8[7 -: CH_W]};
    endfunction

    logic [3*CH_W-1:0] pal_q [DEPTH];
    logic [DEPTH-1:0]  blink_q;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              phase_q, phase_d;

    logic [3*CH_W-1:0] rgb1_q, rgb1_d;
    logic              blink1_q, blink1_d;
    logic              valid1_q, valid1_d;

    logic [CH_W-1:0]   r2_q, g2_q, b2_q;
    logic [CH_W-1:0]   r2_d, g2_d, b2_d;
    logic              valid2_q, valid2_d;

    // Palette storage: defaults on reset, single write port; a same-cycle read sees the old entry.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pal_q[i] <= default_entry(i);
            end
            blink_q <= '0;
        end else if (wr_en) begin
            pal_q[wr_idx]   <= wr_rgb;
            blink_q[wr_idx] <= wr_blink;
        end else begin
            blink_q <= blink_q;
        end
    end

    // Blink timebase: count frames, toggle the phase on each wrap.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (frame_start) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Stage 1 lookup and stage 2 blanking, next-state logic.
    always_comb begin
        rgb1_d   = pal_q[color];
        blink1_d = blink_q[color];
        valid1_d = pix_valid;
        r2_d     = '0;
        g2_d     = '0;
        b2_d     = '0;
        valid2_d = valid1_q;
        if (!valid1_q) begin
            r2_d = '0;
            g2_d = '0;
            b2_d = '0;
        end else if (blink1_q && phase_q) begin
            r2_d = '0;
            g2_d = '0;
            b2_d = '0;
        end else begin
            r2_d = rgb1_q[3*CH_W-1:2*CH_W];
            g2_d = rgb1_q[2*CH_W-1:CH_W];
            b2_d = rgb1_q[CH_W-1:0];
        end
    end

    // Blink timebase and both pipeline stages; reset flushes everything to black/invalid.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt_q    <= '0;
            phase_q  <= 1'b0;
            rgb1_q   <= '0;
            blink1_q <= 1'b0;
            valid1_q <= 1'b0;
            r2_q     <= '0;
            g2_q     <= '0;
            b2_q     <= '0;
            valid2_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            rgb1_q   <= rgb1_d;
            blink1_q <= blink1_d;
            valid1_q <= valid1_d;
            r2_q     <= r2_d;
            g2_q     <= g2_d;
            b2_q     <= b2_d;
            valid2_q <= valid2_d;
        end
    end

    assign VGA_R     = r2_q;
    assign VGA_G     = g2_q;
    assign VGA_B     = b2_q;
    assign out_valid = valid2_q;

endmodule

// File: tb/tb_palette_mapper_pipe.sv
// Directed bench for palette_mapper_pipe: an 8-bit/16-entry instance with a short blink
// period, plus a 4-bit/32-entry instance for the narrow-channel and wide-index defaults.
module tb_palette_mapper_pipe;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_start;
    logic        pix_valid;
    logic [3:0]  color;
    logic        wr_en;
    logic [3:0]  wr_idx;
    logic [23:0] wr_rgb;
    logic        wr_blink;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic        out_valid;

    logic [4:0]  color_b;
    logic [4:0]  wr_idx_b;
    logic [11:0] wr_rgb_b;
    logic [3:0]  r_b, g_b, b_b;
    logic        valid_b;

    int n_tests = 0;
    int n_fail  = 0;

    int exp_r [16] = '{127, 255, 0,   0,   255, 255, 0,   127, 127, 0,   255, 255, 96, 64, 255, 0};
    int exp_g [16] = '{127, 0,   255, 0,   255, 0,   255, 0,   127, 127, 255, 255, 96, 64, 255, 0};
    int exp_b [16] = '{127, 0,   0,   255, 0,   255, 255, 127, 0,   127, 255, 255, 96, 64, 255, 0};

    palette_mapper_pipe #(.IDX_W(4), .CH_W(8), .BLINK_FRAMES(2)) dut (
        .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .pix_valid(pix_valid),
        .color(color), .wr_en(wr_en), .wr_idx(wr_idx), .wr_rgb(wr_rgb), .wr_blink(wr_blink),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .out_valid(out_valid)
    );

    palette_mapper_pipe #(.IDX_W(5), .CH_W(4), .BLINK_FRAMES(16)) dut_b (
        .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .pix_valid(pix_valid),
        .color(color_b), .wr_en(1'b0), .wr_idx(wr_idx_b), .wr_rgb(wr_rgb_b), .wr_blink(1'b0),
        .VGA_R(r_b), .VGA_G(g_b), .VGA_B(b_b), .out_valid(valid_b)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_rgb(input string tag, input int r, input int g, input int b, input int v);
        check_eq({tag, "_r"}, int'(VGA_R), r);
        check_eq({tag, "_g"}, int'(VGA_G), g);
        check_eq({tag, "_b"}, int'(VGA_B), b);
        check_eq({tag, "_v"}, int'(out_valid), v);
    endtask

    task automatic write_entry(input int idx, input int r, input int g, input int b, input logic blk);
        wr_en    = 1'b1;
        wr_idx   = 4'(idx);
        wr_rgb   = {8'(r), 8'(g), 8'(b)};
        wr_blink = blk;
        tick();
        wr_en    = 1'b0;
        wr_blink = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
    endtask

    initial begin
        Reset = 1'b1; frame_start = 1'b0; pix_valid = 1'b0; color = 4'd0;
        wr_en = 1'b0; wr_idx = 4'd0; wr_rgb = 24'd0; wr_blink = 1'b0;
        color_b = 5'd0; wr_idx_b = 5'd0; wr_rgb_b = 12'd0;
        tick(); tick();
        check_rgb("reset", 0, 0, 0, 0);

        // 1: first pixel after release appears two clocks later
        Reset = 1'b0; pix_valid = 1'b1; color = 4'd1;
        tick();
        check_eq("lat1_v", int'(out_valid), 0);
        tick();
        check_rgb("lat2", 255, 0, 0, 1);

        // 2: back-to-back stream of the default table, then invalid pixels
        for (int i = 0; i < 18; i++) begin
            if (i < 16) begin
                pix_valid = 1'b1;
                color     = 4'(i);
            end else begin
                pix_valid = 1'b0;
                color     = 4'd1;
            end
            tick();
            if (i >= 1 && i <= 16) begin
                check_rgb($sformatf("stream%0d", i - 1), exp_r[i-1], exp_g[i-1], exp_b[i-1], 1);
            end else if (i == 17) begin
                check_rgb("invalid", 0, 0, 0, 0);
            end
        end

        // 3: write and read of the same index in the same cycle
        pix_valid = 1'b1; color = 4'd3;
        wr_en = 1'b1; wr_idx = 4'd3; wr_rgb = {8'd10, 8'd20, 8'd30}; wr_blink = 1'b0;
        tick();
        wr_en = 1'b0;
        tick();
        check_rgb("wr_old", 0, 0, 255, 1);
        tick();
        check_rgb("wr_new", 10, 20, 30, 1);

        // 4: blink with period of two frames
        Reset = 1'b1; #2; Reset = 1'b0;
        write_entry(5, 255, 0, 255, 1'b1);
        color = 4'd5;
        tick(); tick();
        check_rgb("blink_p0", 255, 0, 255, 1);
        pulse_frame();
        check_rgb("blink_f1", 255, 0, 255, 1);
        pulse_frame();
        tick(); tick();
        check_rgb("blink_on", 0, 0, 0, 1);
        color = 4'd4;
        tick(); tick();
        check_rgb("noblink4", 255, 255, 0, 1);
        color = 4'd5;
        pulse_frame();
        pulse_frame();
        tick(); tick();
        check_rgb("blink_off", 255, 0, 255, 1);

        // 5: reset mid-stream discards writes and clears the outputs at once
        write_entry(3, 10, 20, 30, 1'b0);
        color = 4'd3;
        tick(); tick();
        check_rgb("pre_rst", 10, 20, 30, 1);
        #2 Reset = 1'b1;
        #1;
        check_rgb("mid_rst", 0, 0, 0, 0);
        @(posedge Clk);
        #1 Reset = 1'b0;
        color = 4'd3;
        tick(); tick();
        check_rgb("post_rst", 0, 0, 255, 1);

        // 6: 4-bit channels, 32 entries
        color_b = 5'd7;
        tick(); tick();
        check_eq("n_r7", int'(r_b), 7);
        check_eq("n_g7", int'(g_b), 0);
        check_eq("n_b7", int'(b_b), 7);
        check_eq("n_v7", int'(valid_b), 1);
        color_b = 5'd20;
        tick(); tick();
        check_eq("n_r20", int'(r_b), 15);
        check_eq("n_g20", int'(g_b), 15);
        check_eq("n_b20", int'(b_b), 15);
        color_b = 5'd12;
        tick(); tick();
        check_eq("n_r12", int'(r_b), 6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
